uart_tx_fifo: RTL and testbench

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

---
 rtl/uart_defs.sv | 14 +
 rtl/uart_fifo_ram.sv | 38 +++
 rtl/uart_tx_fifo.sv | 150 +++++++++++++++
 tb/tb_uart_tx_fifo.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_defs.sv
// Shared UART definitions: default character width and the launch FSM
// state encodings used by the transmit-side FIFO.
package uart_defs;

    localparam int unsigned UART_DATA_BITS = 8;

    localparam int unsigned TX_ST_W = 2;

    localparam logic [TX_ST_W-1:0] ST_IDLE      = 2'd0;
    localparam logic [TX_ST_W-1:0] ST_LAUNCH    = 2'd1;
    localparam logic [TX_ST_W-1:0] ST_WAIT_BUSY = 2'd2;
    localparam logic [TX_ST_W-1:0] ST_WAIT_DONE = 2'd3;

endpackage

// File: rtl/uart_fifo_ram.sv
// Character storage for the TX FIFO: DEPTH x DATA_BITS, synchronous write,
// asynchronous read. Contents are not reset.
//
// Ports:
//   clk_in     write clock
//   wr_en      write strobe
//   wr_addr    write address
//   wr_data    write data
//   rd_addr    read address
//   rd_data_c  read data (combinational from rd_addr)
module uart_fifo_ram
    import uart_defs::*;
#(
    parameter  int unsigned DATA_BITS = UART_DATA_BITS,
    parameter  int unsigned DEPTH     = 16,
    localparam int unsigned ADDR_W    = $clog2(DEPTH)
) (
    input  logic                 clk_in,
    input  logic                 wr_en,
    input  logic [ADDR_W-1:0]    wr_addr,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic [ADDR_W-1:0]    rd_addr,
    output logic [DATA_BITS-1:0] rd_data_c
);

    logic [DATA_BITS-1:0] mem [DEPTH];

    // Synchronous write port
    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Asynchronous read port feeds the tx_data load at launch
    assign rd_data_c = mem[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO with launch FSM in front of a UART transmitter. Characters
// are queued by the producer and handed to the transmitter one at a time,
// each launch waiting for the transmitter's ready flag to drop and rise.
//
// Ports:
//   clk_in    clock, all state changes on its rising edge
//   rst       synchronous active-high reset
//   wr_en     producer write request
//   wr_data   character to enqueue
//   flush     synchronous clear of queued contents (FSM/tx_data untouched)
//   full      level == DEPTH
//   empty     level == 0
//   level     number of stored characters
//   overflow  one-cycle pulse after a write rejected because full
//   tx_ready  transmitter idle flag
//   tx_en     one-cycle launch strobe
//   tx_data   launched character, held until the next launch
module uart_tx_fifo
    import uart_defs::*;
#(
    parameter  int unsigned DATA_BITS = UART_DATA_BITS,
    parameter  int unsigned DEPTH     = 16,
    localparam int unsigned PTR_W     = $clog2(DEPTH),
    localparam int unsigned LVL_W     = PTR_W + 1
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 wr_en,
    input  logic [DATA_BITS-1:0] wr_data,
    input  logic                 flush,
    output logic                 full,
    output logic                 empty,
    output logic [LVL_W-1:0]     level,
    output logic                 overflow,
    input  logic                 tx_ready,
    output logic                 tx_en,
    output logic [DATA_BITS-1:0] tx_data
);

    logic [TX_ST_W-1:0]   state;
    logic [TX_ST_W-1:0]   state_nxt;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [LVL_W-1:0]     level_nxt;
    logic [DATA_BITS-1:0] rd_data_c;
    logic                 wr_accept_c;
    logic                 launch_c;

    // A flush discards any simultaneous write; a full FIFO rejects it
    assign wr_accept_c = wr_en && !full && !flush;

    uart_fifo_ram #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (DEPTH)
    ) u_ram (
        .clk_in    (clk_in),
        .wr_en     (wr_accept_c),
        .wr_addr   (wr_ptr),
        .wr_data   (wr_data),
        .rd_addr   (rd_ptr),
        .rd_data_c (rd_data_c)
    );

    // Launch FSM state register
    always_ff @(posedge clk_in) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Launch FSM next state; tx_ready is ignored in LAUNCH because the
    // transmitter's flag lags its acceptance by a cycle
    always_comb begin
        state_nxt = state;
        launch_c  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty && tx_ready) begin
                    state_nxt = ST_LAUNCH;
                    launch_c  = 1'b1;
                end
            end
            ST_LAUNCH: begin
                state_nxt = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (!tx_ready) begin
                    state_nxt = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Next occupancy; a write and a pop on the same edge cancel out
    always_comb begin
        level_nxt = level;
        if (flush) begin
            level_nxt = '0;
        end else if (wr_accept_c && !launch_c) begin
            level_nxt = level + LVL_W'(1);
        end else if (!wr_accept_c && launch_c) begin
            level_nxt = level - LVL_W'(1);
        end
    end

    // Pointers, status flags and transmitter outputs
    always_ff @(posedge clk_in) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
            tx_en    <= 1'b0;
            tx_data  <= '0;
        end else begin
            level    <= level_nxt;
            full     <= (level_nxt == LVL_W'(DEPTH));
            empty    <= (level_nxt == '0);
            overflow <= wr_en && full;
            tx_en    <= launch_c;
            if (launch_c) begin
                tx_data <= rd_data_c;
            end
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (wr_accept_c) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (launch_c) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: reset state, single-write latency,
// transmitter handshake hold-off, overflow, ordering across pointer wrap,
// and mid-handshake reset/flush.
module tb_uart_tx_fifo;

    localparam int unsigned DATA_BITS = 8;
    localparam int unsigned DEPTH     = 16;
    localparam int unsigned LVL_W     = 5;

    logic                 clk_in = 1'b0;
    logic                 rst;
    logic                 wr_en;
    logic [DATA_BITS-1:0] wr_data;
    logic                 flush;
    logic                 full;
    logic                 empty;
    logic [LVL_W-1:0]     level;
    logic                 overflow;
    logic                 tx_ready;
    logic                 tx_en;
    logic [DATA_BITS-1:0] tx_data;

    // tx_ready comes either from the bench directly or from the transmitter model
    logic tb_ready;
    logic model_en;
    logic model_ready;
    int   busy_len;
    int   m_delay;
    int   m_cnt;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   ovf_cnt;
    logic [DATA_BITS-1:0] got_q [$];
    int                   got_cyc [$];

    assign tx_ready = model_en ? model_ready : tb_ready;

    uart_tx_fifo #(
        .DATA_BITS (DATA_BITS),
        .DEPTH     (DEPTH)
    ) dut (
        .clk_in   (clk_in),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .flush    (flush),
        .full     (full),
        .empty    (empty),
        .level    (level),
        .overflow (overflow),
        .tx_ready (tx_ready),
        .tx_en    (tx_en),
        .tx_data  (tx_data)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    // Launch monitor plus transmitter model: ready stays high for the launch
    // cycle and the one after, then drops for busy_len cycles.
    initial begin
        m_delay = 0;
        m_cnt   = 0;
        forever begin
            @(posedge clk_in);
            #1;
            if (tx_en) begin
                got_q.push_back(tx_data);
                got_cyc.push_back(cyc);
            end
            if (overflow) ovf_cnt++;
            if (model_en) begin
                if (tx_en) begin
                    m_delay = 2;
                end else if (m_delay > 0) begin
                    m_delay--;
                    if (m_delay == 0) begin
                        model_ready = 1'b0;
                        m_cnt       = busy_len;
                    end
                end else if (m_cnt > 0) begin
                    m_cnt--;
                    if (m_cnt == 0) model_ready = 1'b1;
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        wr_en    = 1'b0;
        wr_data  = '0;
        flush    = 1'b0;
        tb_ready = 1'b0;
        model_en = 1'b0;
        tick();
        tick();
        model_ready = 1'b1;
        m_delay     = 0;
        m_cnt       = 0;
        got_q.delete();
        got_cyc.delete();
        ovf_cnt = 0;
        rst     = 1'b0;
    endtask

    task automatic push(input logic [DATA_BITS-1:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic wait_launches(input int n, input int budget);
        int t = 0;
        while (got_q.size() < n && t < budget) begin
            tick();
            t++;
        end
    endtask

    task automatic wait_not_full(input int budget);
        int t = 0;
        while (full && t < budget) begin
            tick();
            t++;
        end
    endtask

    initial begin
        // Reset state
        do_reset();
        check("rst_empty",    32'(empty),    32'd1);
        check("rst_full",     32'(full),     32'd0);
        check("rst_level",    32'(level),    32'd0);
        check("rst_tx_en",    32'(tx_en),    32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_tx_data",  32'(tx_data),  32'd0);

        // Single write: launch on the second edge, one-cycle strobe
        do_reset();
        tb_ready = 1'b1;
        push(8'h55);
        check("sw_level1",     32'(level), 32'd1);
        check("sw_no_bypass",  32'(tx_en), 32'd0);
        tick();
        check("sw_tx_en",      32'(tx_en),   32'd1);
        check("sw_tx_data",    32'(tx_data), 32'h55);
        check("sw_level0",     32'(level),   32'd0);
        check("sw_empty",      32'(empty),   32'd1);
        tick();
        check("sw_tx_en_1cyc", 32'(tx_en),   32'd0);
        repeat (5) tick();
        check("sw_launches",   32'(got_q.size()), 32'd1);

        // Handshake hold-off: second byte waits for ready low-then-high
        do_reset();
        busy_len = 160;
        model_en = 1'b1;
        push(8'h5A);
        push(8'hA3);
        wait_launches(2, 400);
        check("hs_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() >= 2) begin
            check("hs_byte0", 32'(got_q[0]), 32'h5A);
            check("hs_byte1", 32'(got_q[1]), 32'hA3);
            check("hs_gap",   32'(got_cyc[1] - got_cyc[0]), 32'd164);
        end
        repeat (200) tick();
        check("hs_no_double", 32'(got_q.size()), 32'd2);

        // Fill with transmitter not ready, then overflow
        do_reset();
        for (int i = 0; i < 15; i++) push(8'(16 + i));
        check("ovf_level15",  32'(level), 32'd15);
        check("ovf_not_full", 32'(full),  32'd0);
        push(8'h1F);
        check("ovf_level16",  32'(level), 32'd16);
        check("ovf_full",     32'(full),  32'd1);
        check("ovf_no_launch_before_ready", 32'(got_q.size()), 32'd0);
        push(8'hFF);
        check("ovf_pulse",      32'(overflow), 32'd1);
        check("ovf_level_hold", 32'(level),    32'd16);
        tick();
        check("ovf_pulse_1cyc", 32'(overflow), 32'd0);
        busy_len = 2;
        model_en = 1'b1;
        wait_launches(16, 400);
        repeat (20) tick();
        check("ovf_drain_count", 32'(got_q.size()), 32'd16);
        for (int i = 0; i < got_q.size() && i < 16; i++)
            check("ovf_drain_byte", 32'(got_q[i]), 32'(16 + i));
        check("ovf_drain_empty", 32'(empty), 32'd1);

        // Order across pointer wrap with a handshaking transmitter
        do_reset();
        busy_len = 3;
        model_en = 1'b1;
        for (int i = 0; i < 40; i++) begin
            wait_not_full(500);
            push(8'(i));
        end
        wait_launches(40, 2000);
        check("ord_count", 32'(got_q.size()), 32'd40);
        for (int i = 0; i < got_q.size() && i < 40; i++)
            check("ord_byte", 32'(got_q[i]), 32'(i));
        check("ord_no_overflow", 32'(ovf_cnt), 32'd0);

        // Reset in WAIT_BUSY with five queued characters
        do_reset();
        tb_ready = 1'b1;
        for (int i = 0; i < 6; i++) push(8'(8'h60 + i));
        check("mr_level5", 32'(level), 32'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_level0",  32'(level),   32'd0);
        check("mr_empty",   32'(empty),   32'd1);
        check("mr_tx_en",   32'(tx_en),   32'd0);
        check("mr_tx_data", 32'(tx_data), 32'd0);
        push(8'h77);
        tick();
        check("mr_idle_relaunch", 32'(tx_en),   32'd1);
        check("mr_relaunch_data", 32'(tx_data), 32'h77);

        // Flush in WAIT_BUSY: queue cleared, in-flight byte completes
        do_reset();
        tb_ready = 1'b1;
        for (int i = 0; i < 6; i++) push(8'(8'h60 + i));
        check("fl_level5", 32'(level), 32'd5);
        flush   = 1'b1;
        wr_en   = 1'b1;
        wr_data = 8'h99;
        tick();
        flush = 1'b0;
        wr_en = 1'b0;
        check("fl_level0", 32'(level), 32'd0);
        check("fl_empty",  32'(empty), 32'd1);
        tb_ready = 1'b0;
        repeat (3) tick();
        tb_ready = 1'b1;
        repeat (10) tick();
        check("fl_launch_count", 32'(got_q.size()), 32'd1);
        check("fl_tx_data_held", 32'(tx_data),      32'h60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
